video_pattern_gen: RTL and testbench

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

---
 rtl/video_pattern_gen.sv | 173 +++++++++++++++++
 tb/tb_video_pattern_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: raster timing plus noise/bars/grid/gradient colour.
// Latency: one pixel; timing and colour for a pixel appear together after its ce_pix.
// Backpressure: none; free-running, and sinks sample the outputs on ce_pix.
module video_pattern_gen #(
    parameter int H_ACTIVE = 320,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 32,
    parameter int V_ACTIVE = 240,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 15,
    parameter int CE_DIV   = 8,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scandouble,
    input  logic [1:0]    mode,
    input  logic [2:0]    chan_en,
    output logic          ce_pix,
    output logic          hblank,
    output logic          vblank,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start,
    output logic [CW-1:0] r,
    output logic [CW-1:0] g,
    output logic [CW-1:0] b
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(CE_DIV + 1);
    localparam int BAR_W   = H_ACTIVE / 8;

    // Pixel-clock divider. The period is chosen from scandouble in the first
    // clk of each period and then held, so a toggle never bends a strobe.
    logic [DW-1:0] div;
    logic [DW-1:0] p_reg;
    logic [DW-1:0] p_in;
    logic [DW-1:0] p_now;
    logic          ce;

    assign p_in   = scandouble ? DW'(CE_DIV / 2) : DW'(CE_DIV);
    assign p_now  = (div == '0) ? p_in : p_reg;
    assign ce     = (div == p_now - DW'(1));
    assign ce_pix = ce & ~reset;

    // Divider count and period latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div   <= '0;
            p_reg <= DW'(CE_DIV);
        end else begin
            if (div == '0) p_reg <= p_in;
            div <= ce ? '0 : div + DW'(1);
        end
    end

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    int            hx;
    int            vx;
    logic          first_px;
    logic          act;
    logic [1:0]    mode_sh;
    logic [2:0]    en_sh;
    logic [1:0]    eff_mode;
    logic [2:0]    eff_en;
    logic [CW-1:0] fcnt;
    logic [CW-1:0] eff_fcnt;
    logic [15:0]   lfsr;
    logic          fs_reg;

    assign hx       = {{(32-HW){1'b0}}, hcnt};
    assign vx       = {{(32-VW){1'b0}}, vcnt};
    assign first_px = (hcnt == '0) && (vcnt == '0);
    assign act      = (hx < H_ACTIVE) && (vx < V_ACTIVE);
    // The first pixel of a frame already belongs to the newly captured settings.
    assign eff_mode = first_px ? mode : mode_sh;
    assign eff_en   = first_px ? chan_en : en_sh;
    assign eff_fcnt = first_px ? fcnt + CW'(1) : fcnt;

    // Bar index by comparing against constant bar edges; no divider needed.
    logic [2:0] bar_idx;
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (hx >= k * BAR_W) bar_idx = 3'(k);
        end
    end

    // Raw pattern colour for the current pixel, before blanking and channel masks.
    logic [CW-1:0] pat_r;
    logic [CW-1:0] pat_g;
    logic [CW-1:0] pat_b;
    logic          grid_on;
    always_comb begin
        pat_r   = '0;
        pat_g   = '0;
        pat_b   = '0;
        grid_on = (hx[3:0] == 4'd0) || (vx[3:0] == 4'd0) ||
                  (hx == H_ACTIVE - 1) || (vx == V_ACTIVE - 1);
        case (eff_mode)
            2'd0: begin
                pat_r = lfsr[15 -: CW];
                pat_g = lfsr[15 -: CW];
                pat_b = lfsr[15 -: CW];
            end
            2'd1: begin
                // Bars white..black: R drops on bars 2,3,6,7; G on 4..7; B on odd bars.
                pat_r = {CW{~bar_idx[1]}};
                pat_g = {CW{~bar_idx[2]}};
                pat_b = {CW{~bar_idx[0]}};
            end
            2'd2: begin
                pat_r = {CW{grid_on}};
                pat_g = {CW{grid_on}};
                pat_b = {CW{grid_on}};
            end
            default: begin
                pat_r = hx[CW-1:0];
                pat_g = vx[CW-1:0];
                pat_b = eff_fcnt;
            end
        endcase
    end

    // Raster counters, frame shadows, noise LFSR and registered outputs, all on ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt    <= '0;
            vcnt    <= '0;
            fcnt    <= '0;
            lfsr    <= 16'hACE1;
            mode_sh <= 2'd0;
            en_sh   <= 3'b111;
            hblank  <= 1'b0;
            vblank  <= 1'b0;
            hsync   <= 1'b0;
            vsync   <= 1'b0;
            fs_reg  <= 1'b0;
            r       <= '0;
            g       <= '0;
            b       <= '0;
        end else if (ce) begin
            hcnt <= (hx == H_TOTAL - 1) ? '0 : hcnt + HW'(1);
            if (hx == H_TOTAL - 1) begin
                vcnt <= (vx == V_TOTAL - 1) ? '0 : vcnt + VW'(1);
            end
            if (first_px) begin
                mode_sh <= mode;
                en_sh   <= chan_en;
                fcnt    <= eff_fcnt;
            end
            if (act) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            hblank <= (hx >= H_ACTIVE);
            vblank <= (vx >= V_ACTIVE);
            hsync  <= (hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC);
            vsync  <= (vx >= V_ACTIVE + V_FP) && (vx < V_ACTIVE + V_FP + V_SYNC);
            fs_reg <= first_px;
            r      <= (act && eff_en[2]) ? pat_r : '0;
            g      <= (act && eff_en[1]) ? pat_g : '0;
            b      <= (act && eff_en[0]) ? pat_b : '0;
        end
    end

    // The pulse lands on the strobe at which sinks sample pixel (0,0).
    assign frame_start = fs_reg & ce_pix;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: pixel-level reference model checked every clk.
// Stimulus: directed phases plus randomized mode/chan_en/scandouble changes.
// Every non-reset clk compares strobe, timing, frame_start and colour.
module tb_video_pattern_gen;
    localparam int HA = 16, HF = 2, HS = 2, HB = 4;
    localparam int VA = 8, VF = 1, VS = 2, VB = 1;
    localparam int CED = 4, CW = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FPX = HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scandouble = 1'b0;
    logic [1:0] mode = 2'd1;
    logic [2:0] chan_en = 3'b111;
    logic       ce_pix, hblank, vblank, hsync, vsync, frame_start;
    logic [CW-1:0] r, g, b;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CE_DIV(CED), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .scandouble(scandouble), .mode(mode),
        .chan_en(chan_en), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
        .r(r), .g(g), .b(b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hbl;
        logic       vbl;
        logic       hs;
        logic       vs;
        logic       first;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } px_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Expected outputs for the n-th pixel since reset, from the raster rules.
    function automatic px_t model_px(input int n, input logic [1:0] md,
                                     input logic [2:0] en, input logic [15:0] lf);
        px_t p;
        int h, v, fr;
        logic a, w;
        logic [2:0] bar;
        logic [7:0] cr, cg, cb;
        h  = n % HT;
        v  = (n / HT) % VT;
        fr = n / FPX + 1;
        a  = (h < HA) && (v < VA);
        p.hbl   = (h >= HA);
        p.vbl   = (v >= VA);
        p.hs    = (h >= HA + HF) && (h < HA + HF + HS);
        p.vs    = (v >= VA + VF) && (v < VA + VF + VS);
        p.first = (n % FPX) == 0;
        case (h / (HA / 8))
            0: bar = 3'b111;
            1: bar = 3'b110;
            2: bar = 3'b011;
            3: bar = 3'b010;
            4: bar = 3'b101;
            5: bar = 3'b100;
            6: bar = 3'b001;
            default: bar = 3'b000;
        endcase
        w = (h % 16 == 0) || (v % 16 == 0) || (h == HA - 1) || (v == VA - 1);
        case (md)
            2'd0: begin cr = lf[15:8]; cg = lf[15:8]; cb = lf[15:8]; end
            2'd1: begin cr = {8{bar[2]}}; cg = {8{bar[1]}}; cb = {8{bar[0]}}; end
            2'd2: begin cr = {8{w}}; cg = {8{w}}; cb = {8{w}}; end
            default: begin cr = h[7:0]; cg = v[7:0]; cb = fr[7:0]; end
        endcase
        p.r = (a && en[2]) ? cr : 8'h00;
        p.g = (a && en[1]) ? cg : 8'h00;
        p.b = (a && en[0]) ? cb : 8'h00;
        return p;
    endfunction

    // Model state
    int         since = 0, per_cur = CED, n = 0;
    int         tcyc = 0, last_ce_t = 0, last_gap = 0;
    logic       shown_vld = 1'b0;
    px_t        shown;
    logic [15:0] m_lfsr = 16'hACE1;
    logic [1:0] sh_mode = 2'd0;
    logic [2:0] sh_en = 3'b111;

    // Compare process: every falling edge, DUT against model.
    initial begin
        px_t  e;
        int   per;
        logic exp_ce, exp_fs;
        forever begin
            @(negedge clk);
            tcyc++;
            if (reset) begin
                since = 0; n = 0; shown_vld = 1'b0; m_lfsr = 16'hACE1;
                sh_mode = 2'd0; sh_en = 3'b111;
                chk("reset_outputs", 32'({ce_pix, hblank, vblank, hsync, vsync,
                                          frame_start, r, g, b}), 32'd0);
            end else begin
                per = (since == 0) ? (scandouble ? CED / 2 : CED) : per_cur;
                per_cur = per;
                exp_ce = (since == per - 1);
                if (shown_vld) e = shown; else e = '0;
                exp_fs = exp_ce && shown_vld && shown.first;
                chk("ce_pix", 32'(ce_pix), 32'(exp_ce));
                chk("frame_start", 32'(frame_start), 32'(exp_fs));
                chk("timing", 32'({hblank, vblank, hsync, vsync}),
                              32'({e.hbl, e.vbl, e.hs, e.vs}));
                chk("rgb", 32'({r, g, b}), 32'({e.r, e.g, e.b}));
                if (ce_pix) begin
                    last_gap  = tcyc - last_ce_t;
                    last_ce_t = tcyc;
                end
                if (exp_ce) begin
                    if (n % FPX == 0) begin
                        sh_mode = mode;
                        sh_en   = chan_en;
                    end
                    shown = model_px(n, sh_mode, sh_en, m_lfsr);
                    shown_vld = 1'b1;
                    if (!shown.hbl && !shown.vbl) m_lfsr = lfsr_step(m_lfsr);
                    n++;
                    since = 0;
                end else begin
                    since++;
                end
            end
        end
    end

    task automatic wait_ce(input int lim);
        int k;
        logic hit;
        k = 0; hit = 1'b0;
        while (!hit && k < lim) begin
            @(negedge clk);
            k++;
            hit = ce_pix;
        end
        #1;
        if (!hit) begin
            checks++; errors++;
            $display("FAIL wait_ce timeout after %0d clks", lim);
        end
    endtask

    task automatic wait_fs(input int lim);
        int k;
        logic hit;
        k = 0; hit = 1'b0;
        while (!hit && k < lim) begin
            @(negedge clk);
            k++;
            hit = frame_start;
        end
        #1;
        if (!hit) begin
            checks++; errors++;
            $display("FAIL wait_fs timeout after %0d clks", lim);
        end
    endtask

    task automatic wait_pix(input int cnt);
        for (int i = 0; i < cnt; i++) wait_ce(20);
    endtask

    task automatic at_posedge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        px_t p;
        // Hand-computed pins on the model itself.
        chk("pin_lfsr_step", 32'(lfsr_step(16'hACE1)), 32'h59C3);
        p = model_px(0, 2'd1, 3'b111, 16'h0);
        chk("pin_bar_white", 32'({p.r, p.g, p.b}), 32'hFFFFFF);
        p = model_px(4, 2'd1, 3'b111, 16'h0);
        chk("pin_bar_cyan", 32'({p.r, p.g, p.b}), 32'h00FFFF);
        p = model_px(6, 2'd1, 3'b111, 16'h0);
        chk("pin_bar_green", 32'({p.r, p.g, p.b}), 32'h00FF00);
        p = model_px(HT * 3 + 14, 2'd1, 3'b111, 16'h0);
        chk("pin_bar_black", 32'({p.r, p.g, p.b}), 32'h000000);
        p = model_px(19, 2'd1, 3'b111, 16'h0);
        chk("pin_hsync_blank", 32'({p.hbl, p.hs, p.r}), 32'h300);
        p = model_px(HT * 10 + 3, 2'd2, 3'b111, 16'h0);
        chk("pin_vsync", 32'({p.vbl, p.vs, p.r}), 32'h300);
        p = model_px(HT * 7 + 5, 2'd2, 3'b111, 16'h0);
        chk("pin_grid_line7", 32'({p.r, p.g, p.b}), 32'hFFFFFF);

        // Reset, then a colour-bar frame.
        repeat (4) at_posedge();
        reset = 1'b0;
        wait_fs(40);
        chk("bars_px0", 32'({r, g, b}), 32'hFFFFFF);
        wait_pix(4);
        chk("bars_px4", 32'({r, g, b}), 32'h00FFFF);
        wait_pix(2);
        chk("bars_px6", 32'({r, g, b}), 32'h00FF00);
        wait_pix(8);
        chk("bars_px14", 32'({r, g, b}), 32'h000000);
        wait_pix(2);
        chk("bars_px16_blank", 32'({hblank, r, g, b}), 32'h1000000);

        // Switch to gradient with only green at line 3 of frame 2.
        wait_fs(1300);
        wait_pix(HT * 3);
        at_posedge();
        mode = 2'd3; chan_en = 3'b010;
        wait_fs(1300);
        wait_pix(HT * 2 + 5);
        chk("grad_px_5_2", 32'({r, g, b}), 32'h000200);

        // Grid frame.
        at_posedge();
        mode = 2'd2; chan_en = 3'b111;
        wait_fs(1300);
        wait_fs(1300);
        chk("grid_px0", 32'({r, g, b}), 32'hFFFFFF);
        wait_pix(15);
        chk("grid_px15", 32'({r, g, b}), 32'hFFFFFF);
        wait_pix(10);
        chk("grid_px_1_1", 32'({r, g, b}), 32'h000000);

        // Scandouble toggles: one clk before wrap, then mid-period.
        scandouble = 1'b0;
        wait_ce(20);
        repeat (4) @(posedge clk);
        #1;
        scandouble = 1'b1;
        wait_ce(20);
        chk("gap_before_toggle", 32'(last_gap), 32'd4);
        wait_ce(20);
        chk("gap_after_toggle", 32'(last_gap), 32'd2);
        scandouble = 1'b0;
        wait_ce(20);
        chk("gap_back_to_4", 32'(last_gap), 32'd4);
        repeat (2) @(posedge clk);
        #1;
        scandouble = 1'b1;
        wait_ce(20);
        chk("gap_midperiod_keep", 32'(last_gap), 32'd4);
        wait_ce(20);
        chk("gap_midperiod_next", 32'(last_gap), 32'd2);
        scandouble = 1'b0;

        // Randomized input changes at arbitrary points in the frame.
        for (int i = 0; i < 40; i++) begin
            wait_pix($urandom_range(40, 5));
            at_posedge();
            mode       = 2'($urandom);
            chan_en    = 3'($urandom);
            scandouble = 1'($urandom);
        end

        // Noise frame, reset during line 5, noise restarts from the seed.
        at_posedge();
        scandouble = 1'b0; mode = 2'd0; chan_en = 3'b111;
        wait_fs(1300);
        wait_fs(1300);
        wait_pix(HT * 5 + 3);
        at_posedge();
        reset = 1'b1;
        #1;
        chk("reset_immediate", 32'({hblank, vblank, hsync, vsync, r, g, b}), 32'd0);
        repeat (3) at_posedge();
        reset = 1'b0;
        wait_fs(40);
        chk("noise_first_px", 32'({r, g, b}), 32'hACACAC);
        wait_fs(1300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
